// File: rtl/cirno9_tb_pkg.sv
// Shared encodings and defaults for the cirno9 end-of-test monitor.
package cirno9_tb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } state_t;

  localparam logic [31:0] DEFAULT_TOHOST_ADDR = 32'h8000_003c;
  localparam logic [31:0] PASS_T3             = 32'd1;

endpackage

// File: rtl/cirno9_sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; clr and rst both clear it.
module cirno9_sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/cirno9_tohost_monitor.sv
// Watches the core for the riscv-tests tohost spin loop and latches a PASS/FAIL/TIMEOUT verdict.
module cirno9_tohost_monitor
  import cirno9_tb_pkg::*;
#(
  parameter logic [31:0] TOHOST_ADDR = DEFAULT_TOHOST_ADDR,
  parameter int          HIT_COUNT   = 3,
  parameter int          TIMEOUT     = 2500,
  parameter int          CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      pc_i,
  input  logic             retire_i,
  input  logic [31:0]      t3_i,
  output logic [CNT_W-1:0] cycle_cnt_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [31:0]      t3_o,
  output state_t           state_o
);

  localparam int HW = (HIT_COUNT < 1) ? 1 : $clog2(HIT_COUNT + 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(HIT_COUNT - 1);
  // Timeout compare is done at 64 bits so a narrow counter can never alias a large TIMEOUT.
  localparam logic [63:0] TMO_LAST = 64'(TIMEOUT) - 64'd1;

  state_t        state;
  logic [HW-1:0] hits;
  logic          running;
  logic          match;
  logic          end_hit;
  logic          tmo_hit;
  logic [63:0]   cycle_ext;

  assign running   = (state == RUN);
  assign match     = running && (pc_i == TOHOST_ADDR);
  assign end_hit   = match && (hits == HIT_LAST);
  assign cycle_ext = 64'(cycle_cnt_o);
  assign tmo_hit   = running && (TIMEOUT != 0) && (cycle_ext == TMO_LAST);
  assign state_o   = state;

  cirno9_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .inc (running),
    .cnt (cycle_cnt_o)
  );

  cirno9_sat_counter #(.W(CNT_W)) u_instr_cnt (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .inc (running && retire_i),
    .cnt (instr_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      hits      <= '0;
      done_o    <= 1'b0;
      pass_o    <= 1'b0;
      fail_o    <= 1'b0;
      timeout_o <= 1'b0;
      t3_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          state <= RUN;
          hits  <= '0;
        end
        RUN: begin
          if (match) begin
            hits <= hits + 1'b1;
          end
          // An ending hit on the timeout cycle still counts as a normal end.
          if (end_hit) begin
            state  <= DONE;
            done_o <= 1'b1;
            pass_o <= (t3_i == PASS_T3);
            fail_o <= (t3_i != PASS_T3);
            t3_o   <= t3_i;
          end else if (tmo_hit) begin
            state     <= TMO;
            done_o    <= 1'b1;
            fail_o    <= 1'b1;
            timeout_o <= 1'b1;
            t3_o      <= t3_i;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule
